// File: rtl/vote_result_reporter.sv
// Vote result reporter: snapshots three tallies when voting closes, picks the winner,
// and streams a 15-byte checksummed frame over a valid/ready byte interface.
module vote_result_reporter #(
  parameter logic [7:0] HEADER = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_count1,
  input  logic [31:0] i_count2,
  input  logic [31:0] i_count3,
  input  logic        i_voting_over,
  input  logic        i_tx_ready,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  output logic [1:0]  o_winner,
  output logic        o_tie,
  output logic        o_busy,
  output logic        o_done
);

  typedef enum logic [2:0] {IDLE, SNAP, COMPARE, SEND, DONE} state_t;

  state_t      state_reg, state_next;
  logic        vo_prev_reg;
  logic [31:0] snap1_reg, snap2_reg, snap3_reg;
  logic [3:0]  byte_idx_reg;
  logic [7:0]  csum_reg;
  logic [1:0]  winner_reg;
  logic        tie_reg;

  logic        rise;
  logic        xfer;
  logic        last_byte;
  logic        gt1, gt2, gt3;
  logic [1:0]  cmp_winner;
  logic        cmp_tie;
  logic [7:0]  tx_byte;

  assign rise      = i_voting_over & ~vo_prev_reg;
  assign xfer      = (state_reg == SEND) & i_tx_ready;
  assign last_byte = (byte_idx_reg == 4'd14);

  // A candidate wins only with a strictly greatest count; otherwise the max is shared.
  assign gt1        = (snap1_reg > snap2_reg) & (snap1_reg > snap3_reg);
  assign gt2        = (snap2_reg > snap1_reg) & (snap2_reg > snap3_reg);
  assign gt3        = (snap3_reg > snap1_reg) & (snap3_reg > snap2_reg);
  assign cmp_winner = gt1 ? 2'd1 : gt2 ? 2'd2 : gt3 ? 2'd3 : 2'd0;
  assign cmp_tie    = ~(gt1 | gt2 | gt3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (rise) state_next = SNAP;
      SNAP:    state_next = COMPARE;
      COMPARE: state_next = SEND;
      SEND:    if (xfer && last_byte) state_next = DONE;
      DONE:    if (!i_voting_over) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vo_prev_reg  <= 1'b0;
      snap1_reg    <= '0;
      snap2_reg    <= '0;
      snap3_reg    <= '0;
      byte_idx_reg <= '0;
      csum_reg     <= '0;
      winner_reg   <= '0;
      tie_reg      <= 1'b0;
    end else begin
      vo_prev_reg <= i_voting_over;
      if (state_reg == SNAP) begin
        snap1_reg    <= i_count1;
        snap2_reg    <= i_count2;
        snap3_reg    <= i_count3;
        byte_idx_reg <= '0;
        csum_reg     <= '0;
      end
      if (state_reg == COMPARE) begin
        winner_reg <= cmp_winner;
        tie_reg    <= cmp_tie;
      end
      // The checksum byte itself is not folded into the running XOR.
      if (xfer) begin
        if (last_byte) begin
          byte_idx_reg <= '0;
        end else begin
          byte_idx_reg <= byte_idx_reg + 4'd1;
          csum_reg     <= csum_reg ^ tx_byte;
        end
      end
    end
  end

  always_comb begin
    tx_byte = 8'h00;
    case (byte_idx_reg)
      4'd0:    tx_byte = HEADER;
      4'd1:    tx_byte = snap1_reg[31:24];
      4'd2:    tx_byte = snap1_reg[23:16];
      4'd3:    tx_byte = snap1_reg[15:8];
      4'd4:    tx_byte = snap1_reg[7:0];
      4'd5:    tx_byte = snap2_reg[31:24];
      4'd6:    tx_byte = snap2_reg[23:16];
      4'd7:    tx_byte = snap2_reg[15:8];
      4'd8:    tx_byte = snap2_reg[7:0];
      4'd9:    tx_byte = snap3_reg[31:24];
      4'd10:   tx_byte = snap3_reg[23:16];
      4'd11:   tx_byte = snap3_reg[15:8];
      4'd12:   tx_byte = snap3_reg[7:0];
      4'd13:   tx_byte = {tie_reg, 5'b0, winner_reg};
      4'd14:   tx_byte = csum_reg;
      default: tx_byte = 8'h00;
    endcase
  end

  assign o_tx_valid = (state_reg == SEND);
  assign o_tx_data  = (state_reg == SEND) ? tx_byte : 8'h00;
  assign o_busy     = (state_reg == SNAP) | (state_reg == COMPARE) | (state_reg == SEND);
  assign o_done     = (state_reg == DONE);
  assign o_winner   = winner_reg;
  assign o_tie      = tie_reg;

endmodule

// File: tb/tb_vote_result_reporter.sv
// Self-checking bench for vote_result_reporter: table vectors, randomized frames against
// a frame-level reference model, stall, mid-frame count/vote changes and reset abort.
module tb_vote_result_reporter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_count1, i_count2, i_count3;
  logic        i_voting_over, i_tx_ready;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid, o_tie, o_busy, o_done;
  logic [1:0]  o_winner;

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_frame [15];
  logic [1:0] exp_w;
  logic       exp_t;

  typedef struct {
    logic [31:0] c1, c2, c3;
    logic [1:0]  w;
    logic        t;
    logic [7:0]  b13, b14;
  } vec_t;
  vec_t vecs [6];

  vote_result_reporter #(.HEADER(8'hA5)) dut (
    .clk(clk), .rst(rst),
    .i_count1(i_count1), .i_count2(i_count2), .i_count3(i_count3),
    .i_voting_over(i_voting_over), .i_tx_ready(i_tx_ready),
    .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid),
    .o_winner(o_winner), .o_tie(o_tie), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: the whole frame is built from the counts with plain arithmetic.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    logic [31:0] cnt [3];
    logic [31:0] mx;
    int          n;
    logic [7:0]  x;
    cnt[0] = a; cnt[1] = b; cnt[2] = c;
    mx = 0;
    for (int i = 0; i < 3; i++) if (cnt[i] > mx) mx = cnt[i];
    n = 0;
    exp_w = 2'd0;
    for (int i = 0; i < 3; i++) if (cnt[i] == mx) begin n++; exp_w = 2'(i + 1); end
    exp_t = (n > 1);
    if (exp_t) exp_w = 2'd0;
    exp_frame[0] = 8'hA5;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 4; j++)
        exp_frame[1 + 4*i + j] = 8'(cnt[i] >> (24 - 8*j));
    exp_frame[13] = {exp_t, 5'b0, exp_w};
    x = 8'h00;
    for (int k = 0; k < 14; k++) x = x ^ exp_frame[k];
    exp_frame[14] = x;
  endtask

  // rmode: 0 ready always, 1 pattern 1,0,0 repeating, 2 random.
  // stop_after >= 0 returns once that many bytes have transferred (frame left running).
  task automatic run_frame(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                           input int rmode, input bit drop_vo, input int stop_after,
                           output logic [7:0] got13, output logic [7:0] got14);
    int   idx, cyc;
    logic r;
    got13 = 8'h00; got14 = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    i_count1 = a; i_count2 = b; i_count3 = c;
    i_voting_over = 1'b1;
    i_tx_ready = 1'b1;
    model(a, b, c);
    @(negedge clk);
    check("snap_valid", {31'b0, o_tx_valid}, 0);
    check("snap_busy", {31'b0, o_busy}, 1);
    @(negedge clk);
    check("cmp_valid", {31'b0, o_tx_valid}, 0);
    i_count1 = $urandom; i_count2 = $urandom; i_count3 = $urandom;
    @(negedge clk);
    idx = 0; cyc = 0;
    while (idx < 15 && cyc < 300) begin
      check("send_valid", {31'b0, o_tx_valid}, 1);
      check("send_busy", {31'b0, o_busy}, 1);
      check("send_done", {31'b0, o_done}, 0);
      check($sformatf("byte%0d", idx), {24'b0, o_tx_data}, {24'b0, exp_frame[idx]});
      if (idx == 0) begin
        check("send_winner", {30'b0, o_winner}, {30'b0, exp_w});
        check("send_tie", {31'b0, o_tie}, {31'b0, exp_t});
      end
      case (rmode)
        0:       r = 1'b1;
        1:       r = (cyc % 3 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      i_tx_ready = r;
      i_count1 = $urandom; i_count2 = $urandom; i_count3 = $urandom;
      if (drop_vo && idx == 5) i_voting_over = 1'b0;
      if (r) begin
        if (idx == 13) got13 = o_tx_data;
        if (idx == 14) got14 = o_tx_data;
        idx++;
      end
      @(negedge clk);
      cyc++;
      if (stop_after >= 0 && idx == stop_after) return;
    end
    check("frame_timeout", 32'(idx), 15);
    check("end_valid", {31'b0, o_tx_valid}, 0);
    check("end_busy", {31'b0, o_busy}, 0);
    check("end_done", {31'b0, o_done}, 1);
    check("end_winner", {30'b0, o_winner}, {30'b0, exp_w});
    check("end_tie", {31'b0, o_tie}, {31'b0, exp_t});
    if (!drop_vo) begin
      @(negedge clk);
      check("done_hold", {31'b0, o_done}, 1);
      i_voting_over = 1'b0;
    end
    @(negedge clk);
    check("idle_done", {31'b0, o_done}, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, {31'b0, o_tx_valid}, 0);
    check({tag, "_data"}, {24'b0, o_tx_data}, 0);
    check({tag, "_winner"}, {30'b0, o_winner}, 0);
    check({tag, "_tie"}, {31'b0, o_tie}, 0);
    check({tag, "_busy"}, {31'b0, o_busy}, 0);
    check({tag, "_done"}, {31'b0, o_done}, 0);
  endtask

  initial begin
    logic [7:0]  g13, g14;
    logic [31:0] a, b, c;
    vecs[0] = '{32'd5, 32'd3, 32'd2, 2'd1, 1'b0, 8'h01, 8'hA0};
    vecs[1] = '{32'd4, 32'd4, 32'd1, 2'd0, 1'b1, 8'h80, 8'h24};
    vecs[2] = '{32'd0, 32'd0, 32'd0, 2'd0, 1'b1, 8'h80, 8'h25};
    vecs[3] = '{32'd1, 32'd2, 32'd3, 2'd3, 1'b0, 8'h03, 8'hA6};
    vecs[4] = '{32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF, 2'd0, 1'b1, 8'h80, 8'h25};
    vecs[5] = '{32'h80000000, 32'd1, 32'd2, 2'd1, 1'b0, 8'h01, 8'h27};

    rst = 1'b1; i_voting_over = 1'b0; i_tx_ready = 1'b0;
    i_count1 = 0; i_count2 = 0; i_count3 = 0;
    @(negedge clk); @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_valid", {31'b0, o_tx_valid}, 0);
    check("idle_busy", {31'b0, o_busy}, 0);

    for (int v = 0; v < 6; v++) begin
      run_frame(vecs[v].c1, vecs[v].c2, vecs[v].c3, 0, 1'b0, -1, g13, g14);
      check($sformatf("vec%0d_b13", v), {24'b0, g13}, {24'b0, vecs[v].b13});
      check($sformatf("vec%0d_b14", v), {24'b0, g14}, {24'b0, vecs[v].b14});
      check($sformatf("vec%0d_winner", v), {30'b0, o_winner}, {30'b0, vecs[v].w});
      check($sformatf("vec%0d_tie", v), {31'b0, o_tie}, {31'b0, vecs[v].t});
      $display("[TB] vector %0d counts %0d/%0d/%0d b13=%02h b14=%02h", v,
               vecs[v].c1, vecs[v].c2, vecs[v].c3, g13, g14);
    end

    run_frame(32'd5, 32'd3, 32'd2, 1, 1'b0, -1, g13, g14);
    check("stall_b14", {24'b0, g14}, 32'hA0);
    $display("[TB] stalled frame 5/3/2 b14=%02h", g14);

    run_frame(32'd9, 32'd9, 32'd10, 2, 1'b1, -1, g13, g14);
    check("drop_b13", {24'b0, g13}, 32'h03);
    $display("[TB] vote-drop frame 9/9/10 b13=%02h", g13);

    for (int n = 0; n < 12; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        a = $urandom_range(0, 3); b = $urandom_range(0, 3); c = $urandom_range(0, 3);
      end else begin
        a = $urandom; b = $urandom; c = $urandom;
      end
      run_frame(a, b, c, 2, 1'($urandom_range(0, 1)), -1, g13, g14);
      $display("[TB] random frame %0d counts %0h/%0h/%0h b13=%02h b14=%02h", n, a, b, c, g13, g14);
    end

    run_frame(32'd5, 32'd3, 32'd2, 0, 1'b0, 7, g13, g14);
    check("pre_rst_valid", {31'b0, o_tx_valid}, 1);
    rst = 1'b1;
    #1;
    check_all_zero("abort");
    @(negedge clk); @(negedge clk);
    check_all_zero("abort_hold");
    run_frame(32'd5, 32'd3, 32'd2, 0, 1'b0, -1, g13, g14);
    check("restart_b14", {24'b0, g14}, 32'hA0);
    $display("[TB] reset abort then restart frame b14=%02h", g14);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vote_result_reporter.md
VOTE_RESULT_REPORTER -- requirements
Module: vote_result_reporter

Interface
REQ-001 The block SHALL have parameter HEADER, default 8'hA5, the frame start byte.
REQ-002 The block SHALL have port clk, input, 1, rising-edge clock.
REQ-003 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have ports i_count1, i_count2 and i_count3, input, 32 each, candidate vote tallies from the voting machine.
REQ-005 The block SHALL have port i_voting_over, input, 1, level that is high while voting is closed.
REQ-006 The block SHALL have port i_tx_ready, input, 1, downstream byte sink ready.
REQ-007 The block SHALL have port o_tx_data, output, 8, frame byte.
REQ-008 The block SHALL have port o_tx_valid, output, 1, o_tx_data is valid.
REQ-009 The block SHALL have port o_winner, output, 2: 0 = none or tie, 1 to 3 = winning candidate.
REQ-010 The block SHALL have port o_tie, output, 1, the maximum count is shared by two or more candidates.
REQ-011 The block SHALL have port o_busy, output, 1, high from snapshot until the last byte is accepted.
REQ-012 The block SHALL have port o_done, output, 1, frame fully sent.

Function
REQ-013 The block SHALL register i_voting_over each cycle and detect its rising edge as prev=0 and current=1.
REQ-014 The block SHALL implement states IDLE, SNAP, COMPARE, SEND and DONE.
REQ-015 In IDLE, a rising edge of i_voting_over SHALL move the FSM to SNAP, otherwise it SHALL stay in IDLE.
REQ-016 SNAP SHALL latch all three counts into internal registers in one cycle and set o_busy=1; later count changes SHALL be ignored until the next frame.
REQ-017 COMPARE SHALL take one cycle to compute max, o_winner and o_tie from the snapshot using unsigned 32-bit compare.
- A strictly greatest count gives o_winner = its index and o_tie=0.
- A shared maximum, including all counts zero, gives o_winner=0 and o_tie=1.
REQ-018 o_winner and o_tie SHALL be held from the end of COMPARE until the next SNAP or reset.
REQ-019 SEND SHALL emit 15 bytes in this order:
- byte 0: HEADER.
- bytes 1 to 4: snapshot count1, MSB first.
- bytes 5 to 8: snapshot count2, MSB first.
- bytes 9 to 12: snapshot count3, MSB first.
- byte 13: {o_tie, 5'b0, o_winner}.
- byte 14: XOR of bytes 0 to 13.
REQ-020 A byte SHALL transfer on a clock edge where o_tx_valid=1 and i_tx_ready=1.
REQ-021 o_tx_valid SHALL rise on the first cycle of SEND and SHALL stay high until byte 14 transfers, with no gaps between bytes.
REQ-022 While o_tx_valid=1 and i_tx_ready=0, o_tx_data SHALL be held stable.
REQ-023 i_tx_ready SHALL be permitted high at any time, and back-to-back transfers SHALL give one byte per cycle, so a frame takes at least 15 SEND cycles.
REQ-024 A 4-bit byte index SHALL count 0 to 14 and SHALL not wrap within a frame.
REQ-025 A running XOR checksum SHALL be updated on each transfer of bytes 0 to 13.
REQ-026 On transfer of byte 14, the FSM SHALL enter DONE, with o_tx_valid=0, o_busy=0 and o_done=1.
REQ-027 DONE SHALL return to IDLE when i_voting_over=0, and o_done SHALL clear on entry to IDLE.
REQ-028 A fall of i_voting_over during SNAP, COMPARE or SEND SHALL be ignored, and the frame SHALL complete.
REQ-029 Rising edges of i_voting_over outside IDLE SHALL be ignored, with no queuing.
REQ-030 Latency from the rising edge of i_voting_over to the first o_tx_valid SHALL be 3 cycles: edge-detect register, SNAP, COMPARE.

Reset
REQ-031 When rst=1, the block SHALL asynchronously force:
- state IDLE;
- o_tx_valid=0, o_tx_data=0;
- o_winner=0, o_tie=0;
- o_busy=0, o_done=0;
- byte index, checksum, snapshot registers and edge-detect register all 0.
REQ-032 Reset during SEND SHALL abort the frame immediately, and no partial-frame resume SHALL occur.
REQ-033 After release of rst, an i_voting_over that is already high SHALL count as a rising edge on the first cycle and SHALL start a frame.

Verification
REQ-034 Counts 5/3/2, voting_over rises, ready always 1 -> bytes A5 00 00 00 05 00 00 00 03 00 00 00 02 01 A0 on 15 consecutive cycles; o_winner=1, o_tie=0.
REQ-035 Counts 4/4/1 -> byte 13 = 80, checksum = 24; o_winner=0, o_tie=1.
REQ-036 All counts 0 -> byte 13 = 80, checksum = 25, o_tie=1.
REQ-037 Counts 5/3/2 with ready toggled 1,0,0,1,... -> o_tx_data stable during every stall, the same 15 bytes in order, o_done only after byte 14.
REQ-038 Counts change and voting_over falls during SEND -> frame carries the snapshot values; DONE exits to IDLE on the next cycle.
REQ-039 rst pulsed after byte 6 -> o_tx_valid=0 immediately, all outputs 0; with voting_over held high, a fresh frame starting with A5 begins 3 cycles after release.
